match_sequencer: RTL and testbench

Match-flow controller for the pong game. It sequences a match through idle, serve countdown, live play, pause, post-point delay and game-over. It owns both player scores and decides when the ball is re-served and in which direction. It sits between the ball object (which reports points and is frozen and re-served by this block) and the display and seven-segment logic (which consume `match_state` and the scores).

---
 rtl/match_sequencer.sv | 162 ++++++++++++++++
 tb/tb_match_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// Match-flow controller for pong: sequences idle/serve/play/pause/point/over,
// owns both scores and tells the ball object when to freeze and re-serve.
module match_sequencer #(
  parameter int WIN_SCORE = 9,
  parameter int SERVE_MS  = 1000,
  parameter int POINT_MS  = 1500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       start,
  input  logic       pause,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [2:0] match_state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       ball_reset,
  output logic       ball_freeze,
  output logic       serve_dir,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [3:0]  WIN_Q    = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LD = 16'(SERVE_MS);
  localparam logic [15:0] POINT_LD = 16'(POINT_MS);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        start_q;
  logic        pause_q;
  logic [3:0]  p1_q;
  logic [3:0]  p2_q;
  logic        ball_reset_q;
  logic        freeze_q;
  logic        dir_q;
  logic [1:0]  winner_q;

  logic        start_rise;
  logic        pause_rise;
  logic        cnt_expire;
  logic        p1_at_win;
  logic        p2_at_win;

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;
  // A parameter of 0 loads 0, which also satisfies "<= 1" and exits on the first tick.
  assign cnt_expire = clk_1ms && (cnt_q <= 16'd1);
  assign p1_at_win  = (p1_q == WIN_Q);
  assign p2_at_win  = (p2_q == WIN_Q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      p1_q         <= '0;
      p2_q         <= '0;
      ball_reset_q <= 1'b0;
      freeze_q     <= 1'b1;
      dir_q        <= 1'b0;
      winner_q     <= 2'd0;
    end else begin
      start_q      <= start;
      pause_q      <= pause;
      ball_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          freeze_q <= 1'b1;
          if (start_rise) begin
            p1_q         <= '0;
            p2_q         <= '0;
            dir_q        <= 1'b0;
            cnt_q        <= SERVE_LD;
            ball_reset_q <= 1'b1;
            state_q      <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (cnt_expire) begin
            freeze_q <= 1'b0;
            state_q  <= S_PLAY;
          end else if (clk_1ms) begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_PLAY: begin
          if (p1_point) begin
            if (p1_q < WIN_Q) p1_q <= p1_q + 4'd1;
            dir_q    <= 1'b1;
            cnt_q    <= POINT_LD;
            freeze_q <= 1'b1;
            state_q  <= S_POINT;
          end else if (p2_point) begin
            if (p2_q < WIN_Q) p2_q <= p2_q + 4'd1;
            dir_q    <= 1'b0;
            cnt_q    <= POINT_LD;
            freeze_q <= 1'b1;
            state_q  <= S_POINT;
          end else if (pause_rise) begin
            freeze_q <= 1'b1;
            state_q  <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_rise) begin
            freeze_q <= 1'b0;
            state_q  <= S_PLAY;
          end
        end
        S_POINT: begin
          if (cnt_expire) begin
            if (p1_at_win || p2_at_win) begin
              winner_q <= p1_at_win ? 2'd1 : 2'd2;
              state_q  <= S_OVER;
            end else begin
              cnt_q        <= SERVE_LD;
              ball_reset_q <= 1'b1;
              state_q      <= S_SERVE;
            end
          end else if (clk_1ms) begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_OVER: begin
          if (start_rise) begin
            p1_q         <= '0;
            p2_q         <= '0;
            winner_q     <= 2'd0;
            dir_q        <= 1'b0;
            cnt_q        <= SERVE_LD;
            ball_reset_q <= 1'b1;
            state_q      <= S_SERVE;
          end
        end
        default: begin
          freeze_q <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign match_state = state_q;
  assign p1_score    = p1_q;
  assign p2_score    = p2_q;
  assign ball_reset  = ball_reset_q;
  assign ball_freeze = freeze_q;
  assign serve_dir   = dir_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with WIN_SCORE=3, SERVE_MS=3, POINT_MS=2
// and a 1 ms tick every 4 clk cycles.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_1ms = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [2:0] match_state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       ball_reset;
  logic       ball_freeze;
  logic       serve_dir;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  int div    = 0;

  match_sequencer #(
    .WIN_SCORE(3),
    .SERVE_MS (3),
    .POINT_MS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_1ms    (clk_1ms),
    .start      (start),
    .pause      (pause),
    .p1_point   (p1_point),
    .p2_point   (p2_point),
    .match_state(match_state),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .ball_reset (ball_reset),
    .ball_freeze(ball_freeze),
    .serve_dir  (serve_dir),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  // Tick changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    div     = (div + 1) % 4;
    clk_1ms = (div == 0);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle; inputs are changed and outputs read 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    if (clk_1ms) ticks++;
    #1;
  endtask

  task automatic wait_ticks(input string tag, input int target);
    int n;
    n = 0;
    while (ticks < target && n < 200) begin
      cyc();
      n++;
    end
    check({tag, "_tick_timeout"}, int'(ticks >= target), 1);
  endtask

  task automatic pulse_pts(input logic a, input logic b);
    p1_point = a;
    p2_point = b;
    cyc();
    p1_point = 1'b0;
    p2_point = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int st, input int s1, input int s2,
                            input int fr, input int win);
    check({tag, "_state"}, match_state, st);
    check({tag, "_p1"}, p1_score, s1);
    check({tag, "_p2"}, p2_score, s2);
    check({tag, "_freeze"}, ball_freeze, fr);
    check({tag, "_winner"}, winner, win);
  endtask

  // From SERVE entry (ticks zeroed), run the 3-tick countdown into PLAY.
  task automatic serve_to_play(input string tag);
    wait_ticks(tag, 2);
    check({tag, "_still_serve"}, match_state, 1);
    wait_ticks(tag, 3);
    check({tag, "_play"}, match_state, 2);
    check({tag, "_unfrozen"}, ball_freeze, 0);
  endtask

  // From POINT entry (ticks zeroed), run the 2-tick freeze.
  task automatic point_delay(input string tag);
    wait_ticks(tag, 1);
    check({tag, "_still_point"}, match_state, 4);
    wait_ticks(tag, 2);
  endtask

  initial begin
    // Reset with random inputs on the other pins.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start    = 1'($urandom);
      pause    = 1'($urandom);
      p1_point = 1'($urandom);
      p2_point = 1'($urandom);
      cyc();
    end
    check_outs("reset", 0, 0, 0, 1, 0);
    check("reset_ball_reset", ball_reset, 0);
    check("reset_dir", serve_dir, 0);
    start = 0; pause = 0; p1_point = 0; p2_point = 0;
    reset = 1'b1;
    cyc();
    check("idle_hold", match_state, 0);

    // Serve sequence, start held high throughout.
    start = 1'b1;
    cyc();
    ticks = 0;
    check("serve_enter", match_state, 1);
    check("serve_ball_reset_hi", ball_reset, 1);
    check("serve_freeze", ball_freeze, 1);
    cyc();
    check("serve_ball_reset_lo", ball_reset, 0);
    serve_to_play("serve1");
    cyc();
    check("start_held_no_action", match_state, 2);
    check("start_held_no_reset", ball_reset, 0);
    start = 1'b0;

    // Single point for player 1.
    pulse_pts(1, 0);
    ticks = 0;
    check_outs("pt1", 4, 1, 0, 1, 0);
    check("pt1_dir", serve_dir, 1);
    point_delay("pt1");
    check("pt1_reserve", match_state, 1);
    check("pt1_ball_reset", ball_reset, 1);
    ticks = 0;
    cyc();
    check("pt1_ball_reset_lo", ball_reset, 0);

    // Point pulses in SERVE are ignored, then simultaneous points in PLAY.
    pulse_pts(1, 1);
    check_outs("serve_ignore", 1, 1, 0, 1, 0);
    serve_to_play("serve2");
    pulse_pts(1, 1);
    ticks = 0;
    check_outs("both", 4, 2, 0, 1, 0);
    check("both_dir", serve_dir, 1);
    point_delay("both");
    check("both_reserve", match_state, 1);
    ticks = 0;
    serve_to_play("serve3");

    // Pause, point ignored while paused, held pause, resume.
    pause = 1'b1;
    cyc();
    check("pause_enter", match_state, 3);
    check("pause_freeze", ball_freeze, 1);
    pulse_pts(0, 1);
    check_outs("pause_ignore", 3, 2, 0, 1, 0);
    pause = 1'b0;
    cyc();
    check("pause_release", match_state, 3);
    pause = 1'b1;
    cyc();
    check("resume", match_state, 2);
    check("resume_freeze", ball_freeze, 0);
    pause = 1'b0;
    cyc();

    // Player 2 runs to 3; first point arrives together with a pause rise.
    for (int k = 1; k <= 3; k++) begin
      pause = (k == 1);
      pulse_pts(0, 1);
      pause = 1'b0;
      ticks = 0;
      check_outs("p2pt", 4, 2, k, 1, 0);
      check("p2pt_dir", serve_dir, 0);
      point_delay("p2pt");
      if (k < 3) begin
        check("p2pt_reserve", match_state, 1);
        ticks = 0;
        serve_to_play("p2serve");
      end
    end
    check_outs("over", 5, 2, 3, 1, 2);
    pulse_pts(1, 0);
    cyc();
    check_outs("over_hold", 5, 2, 3, 1, 2);

    // Restart from OVER, then reset mid-serve.
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_outs("restart", 1, 0, 0, 1, 0);
    check("restart_ball_reset", ball_reset, 1);
    check("restart_dir", serve_dir, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check_outs("midreset", 0, 0, 0, 1, 0);
    check("midreset_ball_reset", ball_reset, 0);
    reset = 1'b1;
    cyc();
    check("post_reset_idle", match_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
